// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end: hold-FSM encoding and
// the helper that sizes each per-channel counter.
package button_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_HELD   = 2'd1;
    localparam logic [ST_W-1:0] ST_LONG   = 2'd2;
    localparam logic [ST_W-1:0] ST_REPEAT = 2'd3;

    // Bits needed to hold the value max_count (never less than one bit).
    function automatic int cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side and event-side signals of the button conditioner, one bit per channel.
interface button_conditioner_if
    import button_pkg::*;
#(
    parameter int N_BTN = 4
);
    // btn_in is asynchronous raw pin state; repeat_en is synchronous to clk.
    // Every event output is a single-cycle pulse; there is no back-pressure.
    logic [N_BTN-1:0]      btn_in;
    logic [N_BTN-1:0]      repeat_en;
    logic [N_BTN-1:0]      btn_level;
    logic [N_BTN-1:0]      press_pulse;
    logic [N_BTN-1:0]      release_pulse;
    logic [N_BTN-1:0]      long_press;
    logic [N_BTN-1:0]      repeat_pulse;
    logic [ST_W*N_BTN-1:0] state_dbg;

    modport master (
        output btn_in, repeat_en,
        input  btn_level, press_pulse, release_pulse, long_press, repeat_pulse, state_dbg
    );

    modport slave (
        input  btn_in, repeat_en,
        output btn_level, press_pulse, release_pulse, long_press, repeat_pulse, state_dbg
    );

endinterface

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer and hold/auto-repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1048575,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_in,
    input  logic            repeat_en,
    output logic            btn_level,
    output logic            press_pulse,
    output logic            release_pulse,
    output logic            long_press,
    output logic            repeat_pulse,
    output logic [ST_W-1:0] state_dbg
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DW-1:0]          deb_cnt;
    logic                   stable;
    logic                   accept;
    logic [ST_W-1:0]        state;
    logic [HW-1:0]          hold_cnt;
    logic [RW-1:0]          rep_cnt;

    assign synced    = sync_q[SYNC_STAGES-1];
    // The new level is taken on its DEBOUNCE_CYCLES-th consecutive differing cycle.
    assign accept    = (synced != stable) && (deb_cnt == DEB_LAST);
    assign btn_level = stable;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            stable  <= 1'b0;
        end else if (synced == stable) begin
            deb_cnt <= '0;
        end else if (accept) begin
            stable  <= synced;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= accept & synced;
            release_pulse <= accept & ~synced;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            // An accepted edge overrides any hold/repeat timing in the same cycle.
            if (accept) begin
                state    <= synced ? ST_HELD : ST_IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                case (state)
                    ST_HELD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_press <= 1'b1;
                            hold_cnt   <= '0;
                            rep_cnt    <= '0;
                            state      <= repeat_en ? ST_REPEAT : ST_LONG;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_LONG: begin
                        if (repeat_en) begin
                            state   <= ST_REPEAT;
                            rep_cnt <= '0;
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            state   <= ST_LONG;
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_BTN independent conditioned channels.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1048575,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input logic                 clk,
    input logic                 rst_n,
    button_conditioner_if.slave bus
);
    logic [N_BTN-1:0]      level_w;
    logic [N_BTN-1:0]      press_w;
    logic [N_BTN-1:0]      release_w;
    logic [N_BTN-1:0]      long_w;
    logic [N_BTN-1:0]      repeat_w;
    logic [ST_W*N_BTN-1:0] state_w;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1)
    begin : g_param_check
        $error("button_conditioner: SYNC_STAGES must be >= 2 and all *_CYCLES >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_in       (bus.btn_in[i]),
            .repeat_en    (bus.repeat_en[i]),
            .btn_level    (level_w[i]),
            .press_pulse  (press_w[i]),
            .release_pulse(release_w[i]),
            .long_press   (long_w[i]),
            .repeat_pulse (repeat_w[i]),
            .state_dbg    (state_w[ST_W*i +: ST_W])
        );
    end

    assign bus.btn_level     = level_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.long_press    = long_w;
    assign bus.repeat_pulse  = repeat_w;
    assign bus.state_dbg     = state_w;

endmodule
